// File: rtl/ptw_fetch_arbiter.sv
// Round-robin page-walk fetch arbiter.
// Serves NUM_PORTS MMU walkers. Each walker needs one WORD_BYTES-wide word
// from the unified byte memory. The arbiter reads one byte per cycle and
// assembles the word in the chosen byte order. It also range-checks the
// request and aborts the fetch on flush or when the walker withdraws.
module ptw_fetch_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4,
  parameter int MEM_BYTES  = 70000,
  parameter bit ENDIAN_BIG = 1'b0,
  localparam int ID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic                       flush,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [7:0]                 mem_rdata,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [WORD_BYTES*8-1:0]    resp_data,
  output logic                       resp_err,
  output logic                       busy,
  output logic [ID_W-1:0]            grant_id
);

  localparam int               CNT_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WORD_BYTES - 1);
  // The range check runs one bit wider than the address, so base + span never wraps.
  localparam logic [ADDR_W:0]  MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);
  localparam logic [ADDR_W:0]  SPAN      = (ADDR_W + 1)'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_W-1:0]       base;
  logic [ID_W-1:0]         rr_ptr;
  logic [CNT_W-1:0]        cnt;
  logic [WORD_BYTES*8-1:0] word_q, word_next;
  logic [WORD_BYTES*8-1:0] data_q;
  logic                    err_q;

  logic                    found;
  logic [ID_W-1:0]         pick;
  logic [ID_W-1:0]         rr_next;
  logic [ADDR_W-1:0]       sel_addr;
  logic                    out_of_range;
  logic                    grant;
  logic                    cancel;

  // Round-robin scan: find the first requesting port at or above rr_ptr, wrapping around.
  always_comb begin
    int slot;
    // NOTE: every variable assigned here gets a default first, so no path can leave it unassigned (no latch).
    found = 1'b0;
    pick  = '0;
    slot  = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      slot = (int'(rr_ptr) + i) % NUM_PORTS;
      if (!found && req_valid[slot]) begin
        found = 1'b1;
        pick  = ID_W'(slot);
      end
    end
  end

  assign rr_next      = ID_W'((int'(pick) + 1) % NUM_PORTS);
  assign sel_addr     = req_addr[pick*ADDR_W +: ADDR_W];
  assign out_of_range = ({1'b0, sel_addr} + SPAN) >= MEM_LIMIT;

  // Next-state logic. A flush, or the granted walker dropping its request, ends the fetch.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    cancel     = flush || !req_valid[grant_id];
    unique case (state)
      IDLE: begin
        if (!flush && found) begin
          grant      = 1'b1;
          state_next = out_of_range ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (cancel)                state_next = IDLE;
        else if (cnt == LAST_CNT)  state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Place the incoming byte into its slot of the word being assembled.
  always_comb begin
    word_next = word_q;
    if (ENDIAN_BIG) word_next[(WORD_BYTES - 1 - int'(cnt))*8 +: 8] = mem_rdata;
    else            word_next[int'(cnt)*8 +: 8]                     = mem_rdata;
  end

  // Control state, grant bookkeeping and the response registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the edge.
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        base     <= sel_addr;
        grant_id <= pick;
        rr_ptr   <= rr_next;
        cnt      <= '0;
        if (out_of_range) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end
      end
      if (state == FETCH && state_next == FETCH) cnt <= cnt + 1'b1;
      if (state == FETCH && state_next == DONE) begin
        data_q <= word_next;
        err_q  <= 1'b0;
      end
    end
  end

  // Byte assembly register, written on every fetch cycle.
  always_ff @(posedge clk) begin
    // NOTE: no reset here. Every slot is rewritten before a completed word is copied into data_q.
    if (state == FETCH) word_q <= word_next;
  end

  // Response strobe: goes to the granted port only while the request is still live.
  always_comb begin
    resp_valid = '0;
    if (state == DONE && !cancel) resp_valid[grant_id] = 1'b1;
  end

  assign busy      = (state != IDLE);
  assign mem_addr  = (state == FETCH) ? base + ADDR_W'(cnt) : '0;
  assign resp_data = data_q;
  assign resp_err  = err_q;

endmodule

// File: tb/tb_ptw_fetch_arbiter.sv
// Bench for ptw_fetch_arbiter. It drives two instances with the same inputs:
// one assembles little-endian, the other big-endian. Expected outputs come
// from a transaction-level model: it picks the grant round-robin, counts the
// response latency in cycles, and builds each word arithmetically from the
// memory array.
module tb_ptw_fetch_arbiter;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int WB = 4;
  localparam int MB = 70000;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [NP-1:0]     req_valid;
  logic [NP*AW-1:0]  req_addr;
  logic [AW-1:0]     mem_addr, mem_addr_be;
  logic [7:0]        rdata_le, rdata_be;
  logic [NP-1:0]     resp_valid, resp_valid_be;
  logic [WB*8-1:0]   resp_data, resp_data_be;
  logic              resp_err, resp_err_be;
  logic              busy, busy_be;
  logic [1:0]        grant_id, grant_id_be;

  logic [7:0] mem [0:MB-1];

  assign rdata_le = (mem_addr    < AW'(MB)) ? mem[mem_addr[16:0]]    : 8'h00;
  assign rdata_be = (mem_addr_be < AW'(MB)) ? mem[mem_addr_be[16:0]] : 8'h00;

  ptw_fetch_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .WORD_BYTES(WB), .MEM_BYTES(MB), .ENDIAN_BIG(1'b0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
    .mem_addr(mem_addr), .mem_rdata(rdata_le), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .grant_id(grant_id));

  ptw_fetch_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .WORD_BYTES(WB), .MEM_BYTES(MB), .ENDIAN_BIG(1'b1)) dut_be (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
    .mem_addr(mem_addr_be), .mem_rdata(rdata_be), .resp_valid(resp_valid_be), .resp_data(resp_data_be),
    .resp_err(resp_err_be), .busy(busy_be), .grant_id(grant_id_be));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Requester stimulus state.
  logic [NP-1:0] pend = '0;
  logic [NP-1:0] cool = '0;
  logic [AW-1:0] paddr [NP];
  logic          st_rst = 1'b1;
  logic          st_flush = 1'b0;

  // Reference model state.
  int          cyc = 0;
  int          serving = -1;
  int          rr = 0;
  int          resp_at = 0;
  int          grant_cyc = 0;
  logic [1:0]  last_grant = '0;
  logic [AW-1:0] cur_base = '0;
  logic        cur_err = 1'b0;
  logic [63:0] cur_le = '0, cur_be = '0;
  logic [63:0] last_le = '0, last_be = '0;
  logic        last_err = 1'b0;

  // Observations kept for the directed checks.
  logic [63:0] obs_le, obs_be;
  logic        obs_err;
  int          order[$];
  int          resp_cyc[$];

  function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
    return (a < AW'(MB)) ? mem[a[16:0]] : 8'h00;
  endfunction

  function automatic logic [63:0] word_le(input logic [AW-1:0] a);
    logic [63:0] w = '0;
    for (int i = 0; i < WB; i++) w |= 64'(mem_rd(a + AW'(i))) << (8 * i);
    return w;
  endfunction

  function automatic logic [63:0] word_be(input logic [AW-1:0] a);
    logic [63:0] w = '0;
    for (int i = 0; i < WB; i++) w |= 64'(mem_rd(a + AW'(i))) << (8 * (WB - 1 - i));
    return w;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    int unsigned r = $urandom_range(0, 99);
    if (r < 70)      return AW'($urandom_range(0, MB - WB));
    else if (r < 85) return AW'($urandom_range(MB - 10, MB + 5));
    else             return AW'($urandom());
  endfunction

  task automatic raise(input int p, input logic [AW-1:0] a);
    pend[p]  = 1'b1;
    cool[p]  = 1'b0;
    paddr[p] = a;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step();
    logic [NP-1:0] exp_v;
    @(posedge clk);
    #1;
    rst   = st_rst;
    flush = st_flush;
    for (int p = 0; p < NP; p++) begin
      req_valid[p]           = pend[p];
      req_addr[p*AW +: AW]   = paddr[p];
    end
    @(negedge clk);

    exp_v = '0;
    if (serving >= 0 && cyc == resp_at && !flush && req_valid[serving]) exp_v[serving] = 1'b1;
    check("resp_valid", resp_valid, exp_v);
    check("resp_valid_be", resp_valid_be, exp_v);
    check("busy", busy, serving >= 0);
    check("grant_id", grant_id, last_grant);
    check("resp_data", resp_data, last_le);
    check("resp_data_be", resp_data_be, last_be);
    if (exp_v != '0) begin
      check("resp_err", resp_err, last_err);
      check("resp_err_be", resp_err_be, last_err);
    end
    if (serving >= 0 && !cur_err && cyc > grant_cyc && cyc <= grant_cyc + WB)
      check("mem_addr", mem_addr, cur_base + AW'(cyc - grant_cyc - 1));

    if (resp_valid != '0) begin
      obs_le  = 64'(resp_data);
      obs_be  = 64'(resp_data_be);
      obs_err = resp_err;
      resp_cyc.push_back(cyc);
      for (int p = 0; p < NP; p++) if (resp_valid[p]) order.push_back(p);
    end

    if (serving >= 0) begin
      if (flush || !req_valid[serving]) begin
        serving = -1;
      end else if (cyc == resp_at) begin
        pend[serving] = 1'b0;
        cool[serving] = 1'b1;
        serving = -1;
      end else if (cyc + 1 == resp_at) begin
        last_le  = cur_le;
        last_be  = cur_be;
        last_err = 1'b0;
      end
    end else if (!flush) begin
      for (int i = 0; i < NP; i++) begin
        int k = (rr + i) % NP;
        if (serving < 0 && req_valid[k]) begin
          serving    = k;
          rr         = (k + 1) % NP;
          last_grant = 2'(k);
          grant_cyc  = cyc;
          cur_base   = req_addr[k*AW +: AW];
          cur_err    = (64'(cur_base) + WB - 1) >= MB;
          resp_at    = cyc + (cur_err ? 1 : WB + 1);
          if (cur_err) begin
            last_le  = '0;
            last_be  = '0;
            last_err = 1'b1;
          end else begin
            cur_le = word_le(cur_base);
            cur_be = word_be(cur_base);
          end
        end
      end
    end
    if (rst) begin
      serving    = -1;
      rr         = 0;
      last_grant = '0;
      last_le    = '0;
      last_be    = '0;
      last_err   = 1'b0;
    end
    cyc++;
  endtask

  task automatic run_idle();
    int n = 0;
    while ((serving >= 0 || pend != '0) && n < 200) begin
      step();
      n++;
    end
    check("idle_reached", (serving < 0 && pend == '0), 1'b1);
  endtask

  initial begin
    int start;
    int n;
    for (int i = 0; i < MB; i++) mem[i] = 8'($urandom());
    mem[32'h100] = 8'h11;
    mem[32'h101] = 8'h22;
    mem[32'h102] = 8'h33;
    mem[32'h103] = 8'h44;
    for (int p = 0; p < NP; p++) paddr[p] = '0;
    rst = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    req_addr = '0;

    // Reset.
    step();
    step();
    st_rst = 1'b0;
    step();
    check("rst_mem_addr", mem_addr, '0);

    // Single fetch, both byte orders.
    order.delete();
    resp_cyc.delete();
    start = cyc;
    raise(0, 32'h100);
    run_idle();
    check("single_le", obs_le, 64'h44332211);
    check("single_be", obs_be, 64'h11223344);
    check("single_err", obs_err, 1'b0);
    check("single_lat", resp_cyc[0] - start, 5);

    // Contention from reset, then port0 re-requests right after its response.
    st_rst = 1'b1;
    step();
    st_rst = 1'b0;
    order.delete();
    resp_cyc.delete();
    start = cyc;
    raise(0, 32'h1000);
    raise(1, 32'h2000);
    raise(2, 32'h3000);
    n = 0;
    while (order.size() == 0 && n < 50) begin
      step();
      n++;
    end
    step();
    raise(0, 32'h4000);
    run_idle();
    check("cont_count", order.size(), 4);
    check("cont_ord0", order[0], 0);
    check("cont_ord1", order[1], 1);
    check("cont_ord2", order[2], 2);
    check("cont_ord3", order[3], 0);
    check("cont_lat0", resp_cyc[0] - start, 5);
    check("cont_lat1", resp_cyc[1] - start, 11);
    check("cont_lat2", resp_cyc[2] - start, 17);
    check("cont_data", obs_le, word_le(32'h4000));

    // Out of range, and the last in-range word.
    resp_cyc.delete();
    start = cyc;
    raise(1, 32'(MB - 3));
    run_idle();
    check("oor_err", obs_err, 1'b1);
    check("oor_data", obs_le, 64'h0);
    check("oor_lat", resp_cyc[0] - start, 1);
    raise(1, 32'(MB - 4));
    run_idle();
    check("edge_err", obs_err, 1'b0);
    check("edge_data", obs_le, word_le(32'(MB - 4)));

    // Flush during the second fetch cycle, then the same request completes.
    order.delete();
    raise(0, 32'h200);
    step();
    step();
    st_flush = 1'b1;
    step();
    st_flush = 1'b0;
    check("abort_noresp", order.size(), 0);
    step();
    check("abort_busy", busy, 1'b0);
    run_idle();
    check("abort_data", obs_le, word_le(32'h200));

    // Reset in the third fetch cycle; the round-robin pointer must restart at 0.
    raise(0, 32'h300);
    step();
    step();
    step();
    st_rst = 1'b1;
    step();
    st_rst = 1'b0;
    raise(1, 32'h500);
    raise(2, 32'h600);
    order.delete();
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_id, 2'd0);
    check("rst_data", resp_data, '0);
    run_idle();
    check("rst_rr_first", order[0], 0);

    // The granted port withdraws during fetch: no response.
    order.delete();
    raise(1, 32'h400);
    step();
    step();
    pend[1] = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("drop_noresp", order.size(), 0);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (cool[p]) cool[p] = 1'b0;
        else if (!pend[p] && $urandom_range(0, 3) == 0) raise(p, rand_addr());
        else if (pend[p] && $urandom_range(0, 49) == 0) pend[p] = 1'b0;
        else if (pend[p] && $urandom_range(0, 19) == 0) paddr[p] = rand_addr();
      end
      st_flush = ($urandom_range(0, 39) == 0);
      st_rst   = ($urandom_range(0, 199) == 0);
      step();
    end
    st_flush = 1'b0;
    st_rst   = 1'b0;
    run_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ptw_fetch_arbiter.md
Name: ptw_fetch_arbiter

Overview:
- Parametrised successor to the single-pair IMEM/DMEM page-walk fetch FSM.
- Serves NUM_PORTS MMU walkers that each need a WORD_BYTES-wide word (a PTE) from the unified byte memory.
- Arbitrates round-robin, reads one byte per cycle over the memory's byte read port, and assembles the word in a selectable byte order.
- Adds range checking and abort/flush, which the per-MMU fixed fetch did not have.

Parameters:
- NUM_PORTS, 2: number of requesting walkers (1..8).
- ADDR_W, 32: byte-address width.
- WORD_BYTES, 4: bytes per fetched word (1..8).
- MEM_BYTES, 70000: valid memory bytes; addresses 0..MEM_BYTES-1.
- ENDIAN_BIG, 0: 0 = little-endian assembly, 1 = big-endian assembly.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_PORTS  per-port request level, held until that port's resp_valid
- req_addr  in  NUM_PORTS*ADDR_W  per-port byte address; port p occupies bits [p*ADDR_W +: ADDR_W]
- flush  in  1  abort any in-flight fetch (e.g. satp write, sfence)
- mem_addr  out  ADDR_W  byte read address to unified memory
- mem_rdata  in  8  byte at mem_addr, combinational (same cycle)
- resp_valid  out  NUM_PORTS  one-hot, one-cycle pulse to the served port
- resp_data  out  WORD_BYTES*8  assembled word, valid while any resp_valid bit is high
- resp_err  out  1  out-of-range access, qualified by resp_valid
- busy  out  1  high in FETCH or DONE
- grant_id  out  $clog2(NUM_PORTS) (min 1)  index of the port being served

Behaviour:
- Reset values: state IDLE, resp_valid=0, resp_data=0, resp_err=0, busy=0, grant_id=0, mem_addr=0, rr pointer=0, byte counter=0.
- Reset mid-fetch: same as above; no response is produced.

States:
- IDLE:
  - Scan req_valid starting at rr pointer, upward with wrap.
  - First set bit k is granted: latch base=req_addr[k], grant_id=k, rr pointer=(k+1) mod NUM_PORTS.
  - Range check: if base + WORD_BYTES - 1 >= MEM_BYTES (computed in ADDR_W+1 bits, so no wrap), go to DONE with resp_err=1 and data 0.
  - Otherwise clear the counter and go to FETCH.
- FETCH:
  - mem_addr = base + cnt.
  - Each cycle capture mem_rdata into byte slot cnt, then cnt++.
  - Slot i maps to bits [8i+7:8i] when ENDIAN_BIG=0, or to bits [8(WORD_BYTES-1-i)+7 : 8(WORD_BYTES-1-i)] when ENDIAN_BIG=1.
  - After slot WORD_BYTES-1 is captured, go to DONE.
- DONE:
  - resp_valid[grant_id]=1 for exactly one cycle, with resp_data and resp_err stable.
  - Next state is IDLE.
  - resp_data holds its value until the next DONE.

Timing and handshake:
- Uncontended latency: request seen in IDLE at cycle 0 -> FETCH cycles 1..WORD_BYTES -> resp_valid at cycle WORD_BYTES+1. Default: 5 cycles.
- Out-of-range response arrives at cycle 1.
- The requester must drop req_valid in the cycle after resp_valid. A request still high in the following IDLE cycle is a new request.

Boundary conditions:
- Cancel: if req_valid[grant_id] falls during FETCH or DONE, or flush=1 in any state, go to IDLE at the next edge, assert no resp_valid, and keep the rr pointer as already advanced.
- flush in IDLE also suppresses a grant that cycle.
- Simultaneous requests: one grant per IDLE visit; the others keep waiting.
  - A waiting port is served within NUM_PORTS grants (no starvation).
- A port's req_addr changing while it is granted is ignored; base is latched.
- NUM_PORTS=1: rr pointer stays 0, grant_id is always 0.

Test Plan:
- Single fetch: mem[0x100..0x103]=0x11,0x22,0x33,0x44; port0 requests 0x100 -> resp_valid=01 at cycle 5, resp_data=0x44332211, resp_err=0; mem_addr steps 0x100..0x103 in cycles 1..4.
- ENDIAN_BIG=1, same memory and request -> resp_data=0x11223344.
- Contention: NUM_PORTS=3, all ports request different addresses in the same cycle from reset -> served in order 0,1,2; responses at cycles 5,11,17, each with correct data. Re-request by port0 right after its response -> served after port2.
- Out of range: MEM_BYTES=70000, request 69997 -> resp_valid at cycle 1, resp_err=1, data 0. Request 69996 -> normal fetch, err=0.
- Abort: flush high in cycle 2 of FETCH -> no resp_valid, busy=0 next cycle. Next request completes normally with fresh data.
- Reset and cancel: rst in cycle 3 of FETCH -> all outputs at reset values next cycle, rr pointer=0. Granted port dropping req_valid in FETCH -> no response.
